// File: rtl/hdc_pkg.sv
// Shared types and defaults for the HDC bundling path.
package hdc_pkg;

  localparam int unsigned DIM_DEFAULT   = 1023;
  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int          CNT_MAX       = (2 ** (CNT_W_DEFAULT - 1)) - 1;

  typedef logic [DIM_DEFAULT:0] hv_t;

  typedef enum logic [0:0] {
    ACC,
    EMIT
  } bundler_state_t;

  // Symmetric saturation bound for a CNT_W-bit two's-complement counter.
  function automatic int cnt_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/hv_bundler_if.sv
// Beat stream in, bundled result out; slave is the bundler side.
interface hv_bundler_if #(
  parameter int unsigned DIM = hdc_pkg::DIM_DEFAULT
) ();

  logic         store;
  logic [DIM:0] core_result;
  logic         last;
  logic         result_ready;
  logic         result_valid;
  logic [DIM:0] result_data;
  logic [15:0]  result_count;
  logic         overrun;

  modport master (
    output store, core_result, last, result_ready,
    input  result_valid, result_data, result_count, overrun
  );

  modport slave (
    input  store, core_result, last, result_ready,
    output result_valid, result_data, result_count, overrun
  );

endinterface

// File: rtl/bundle_bit_counter.sv
// One signed saturating vote counter for a single hypervector bit.
module bundle_bit_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic pos,
  output logic zero
);
  import hdc_pkg::*;

  localparam logic signed [CNT_W-1:0] CntMax = CNT_W'(cnt_max(int'(CNT_W)));
  localparam logic signed [CNT_W-1:0] CntMin = -CntMax;

  logic signed [CNT_W-1:0] cnt_q;

  // Clear dominates; saturation is symmetric so the most negative code is never used.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec && (cnt_q != CntMin)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);
  assign pos  = !cnt_q[CNT_W-1] && !zero;

endmodule

// File: rtl/hv_bundler.sv
// Majority bundler over one beat sequence with a valid/ready result port.
// Optional HV_BUNDLER_TIEBREAK_EN: tied bits take the first beat of the sequence.
module hv_bundler #(
  parameter int unsigned DIM   = hdc_pkg::DIM_DEFAULT,
  parameter int unsigned CNT_W = hdc_pkg::CNT_W_DEFAULT
) (
  input logic        clk,
  input logic        run,
  hv_bundler_if.slave bus
);
  import hdc_pkg::*;

  bundler_state_t state_q;
  logic [15:0]    count_q;
  logic           overrun_q;

  logic           accept;
  logic           handshake;
  logic           clear;
  logic [DIM:0]   pos;
  logic [DIM:0]   zero;
  logic [DIM:0]   tie_bits;

  assign accept    = (state_q == ACC) && bus.store;
  assign handshake = (state_q == EMIT) && bus.result_ready;
  assign clear     = !run || handshake;

  for (genvar gi = 0; gi <= DIM; gi++) begin : g_cnt
    bundle_bit_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .clear(clear),
      .inc  (accept && bus.core_result[gi]),
      .dec  (accept && !bus.core_result[gi]),
      .pos  (pos[gi]),
      .zero (zero[gi])
    );
  end

`ifdef HV_BUNDLER_TIEBREAK_EN
  logic [DIM:0] tie_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      tie_q <= '0;
    end else if (accept && (count_q == 16'd0)) begin
      tie_q <= bus.core_result;
    end
  end

  assign tie_bits = tie_q;
`else
  assign tie_bits = '0;
`endif

  // Beats seen while a result is pending are dropped; overrun only clears on reset.
  always_ff @(posedge clk) begin
    if (!run) begin
      state_q   <= ACC;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            if (bus.last) state_q <= EMIT;
          end
        end
        EMIT: begin
          if (bus.store) overrun_q <= 1'b1;
          if (bus.result_ready) begin
            state_q <= ACC;
            count_q <= '0;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  always_comb begin
    bus.result_valid = (state_q == EMIT);
    bus.result_data  = '0;
    bus.result_count = '0;
    bus.overrun      = overrun_q;
    if (state_q == EMIT) begin
      bus.result_data  = pos | (zero & tie_bits);
      bus.result_count = count_q;
    end
  end

endmodule

// File: tb/tb_hv_bundler.sv
// Directed bench for hv_bundler (DIM=7, CNT_W=4) with a vote-count reference model.
module tb_hv_bundler;

  localparam int unsigned DIM   = 7;
  localparam int unsigned CNT_W = 4;
  localparam int          VMAX  = 7;

  logic clk;
  logic run;

  hv_bundler_if #(.DIM(DIM)) bus ();

  hv_bundler #(
    .DIM  (DIM),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .run(run),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: per-bit vote totals clamped to +/-VMAX, plus sequence bookkeeping.
  int          votes [DIM+1];
  int          beats;
  bit          pending;
  bit          m_overrun;
  logic [7:0]  first_beat;
  bit          model_live = 1'b0;

  function automatic logic [7:0] majority();
    logic [7:0] r;
    for (int i = 0; i <= DIM; i++) begin
      if (votes[i] > 0)      r[i] = 1'b1;
      else if (votes[i] < 0) r[i] = 1'b0;
`ifdef HV_BUNDLER_TIEBREAK_EN
      else                   r[i] = first_beat[i];
`else
      else                   r[i] = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i <= DIM; i++) votes[i] = 0;
    beats      = 0;
    first_beat = '0;
  endtask

  always @(posedge clk) begin
    if (!run) begin
      model_clear();
      pending    = 1'b0;
      m_overrun  = 1'b0;
      model_live = 1'b1;
    end else if (pending) begin
      if (bus.store) m_overrun = 1'b1;
      if (bus.result_ready) begin
        model_clear();
        pending = 1'b0;
      end
    end else if (bus.store) begin
      if (beats == 0) first_beat = bus.core_result;
      for (int i = 0; i <= DIM; i++) begin
        if (bus.core_result[i]) votes[i] = (votes[i] < VMAX) ? votes[i] + 1 : VMAX;
        else                    votes[i] = (votes[i] > -VMAX) ? votes[i] - 1 : -VMAX;
      end
      if (beats < 65535) beats++;
      if (bus.last) pending = 1'b1;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check("cyc_valid", 32'(bus.result_valid), 32'(pending));
      check("cyc_data", 32'(bus.result_data), pending ? 32'(majority()) : 32'd0);
      check("cyc_count", 32'(bus.result_count), pending ? 32'(beats) : 32'd0);
      check("cyc_overrun", 32'(bus.overrun), 32'(m_overrun));
    end
  end

  task automatic step(logic s, logic [7:0] d, logic l);
    bus.store       = s;
    bus.core_result = d;
    bus.last        = l;
    @(negedge clk);
  endtask

  task automatic expect_result(string name, logic [7:0] data, logic [15:0] cnt);
    check({name, "_valid"}, 32'(bus.result_valid), 32'd1);
    check({name, "_data"}, 32'(bus.result_data), 32'(data));
    check({name, "_count"}, 32'(bus.result_count), 32'(cnt));
  endtask

  initial begin
    run              = 1'b0;
    bus.store        = 1'b0;
    bus.core_result  = '0;
    bus.last         = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);

    // Reset with beats presented: nothing may accumulate.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_count", 32'(bus.result_count), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    run = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("post_rst_valid", 32'(bus.result_valid), 32'd0);

    // Majority of three, result exactly one cycle after the last beat.
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    check("maj_not_early", 32'(bus.result_valid), 32'd0);
    step(1'b1, 8'hAA, 1'b1);
    expect_result("maj3", 8'hE8, 16'd3);
    step(1'b0, 8'h00, 1'b0);
    check("maj_drop", 32'(bus.result_valid), 32'd0);

    // Two-beat tie.
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h3C, 1'b1);
`ifdef HV_BUNDLER_TIEBREAK_EN
    expect_result("tie", 8'hF0, 16'd2);
`else
    expect_result("tie", 8'h30, 16'd2);
`endif
    step(1'b0, 8'h00, 1'b0);

    // Saturation: +7 cap, one decrement leaves +6.
    for (int i = 0; i < 20; i++) step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    expect_result("sat", 8'hFF, 16'd21);
    step(1'b0, 8'h00, 1'b0);

    // Backpressure with beats arriving while the result is held.
    bus.result_ready = 1'b0;
    step(1'b1, 8'h0F, 1'b1);
    expect_result("bp_first", 8'h0F, 16'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 1'b0);
    expect_result("bp_held", 8'h0F, 16'd1);
    check("bp_overrun", 32'(bus.overrun), 32'd1);
    bus.result_ready = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("bp_release", 32'(bus.result_valid), 32'd0);
    step(1'b1, 8'h55, 1'b1);
    expect_result("bp_clean", 8'h55, 16'd1);
    check("bp_sticky", 32'(bus.overrun), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    run = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    run = 1'b1;

    // Reset mid-sequence discards the partial bundle.
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    run = 1'b0;
    step(1'b1, 8'hFF, 1'b0);
    run = 1'b1;
    step(1'b1, 8'h01, 1'b1);
    expect_result("midrst", 8'h01, 16'd1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hv_bundler.md
Name: hv_bundler

Overview:
- Downstream of the HDC core; consumes its `store`/`core_result`/`last` beat stream.
- Bundles every hypervector of one sequence into a bit-wise majority hypervector using per-bit signed saturating counters.
- On the `last` beat it presents the thresholded result and beat count on a valid/ready output toward the DMA/readout path, then clears for the next sequence.

Parameters:
- DIM, 1023, MSB index of a hypervector (vector width is DIM+1).
- CNT_W, 8, width of each signed per-bit counter in two's complement (range ±(2^(CNT_W-1)-1)).

Ports:
- clk  in  1  single clock, rising edge.
- run  in  1  reset: synchronous, active-low (low = reset).
- store  in  1  a beat on `core_result` is valid this cycle.
- core_result  in  DIM+1  hypervector beat.
- last  in  1  qualifies the final beat of a sequence; meaningful only with `store`.
- result_ready  in  1  downstream accepts the result.
- result_valid  out  1  bundled result available.
- result_data  out  DIM+1  bundled (majority) hypervector.
- result_count  out  16  number of beats bundled; saturates at 16'hFFFF.
- overrun  out  1  sticky flag: a beat arrived while a result was pending and was dropped.

Behaviour:
- Reset (run=0, sampled at clk edge):
  - all counters = 0, state = ACC;
  - result_valid = 0, result_data = 0, result_count = 0, overrun = 0.
- States:
  - ACC (accumulating).
  - EMIT (result held).
- ACC, store=1, per bit i:
  - core_result[i]=1 increments cnt[i], 0 decrements it;
  - saturates at +max / -max, with no wrap.
  - Beat count increments, saturating at 16'hFFFF.
- ACC, store=1 and last=1: the beat is accumulated as above, and the next state is EMIT.
- last=1 with store=0 is ignored.
- EMIT:
  - result_valid=1;
  - result_data[i] = 1 if cnt[i]>0, 0 if cnt[i]<0; tie (cnt[i]==0) per the Optional Feature;
  - result_count = beat count.
  - Outputs are stable until the handshake.
- Latency: the last beat sampled at edge N gives result_valid=1 in the cycle after edge N.
- Handshake: result_valid & result_ready sampled at an edge clears all counters and the beat count, and returns to ACC. result_valid drops in the next cycle.
  - A zero-bubble restart is not required.
  - A beat arriving in the same cycle as that handshake is treated as an EMIT-state beat (dropped, overrun=1).
- EMIT with store=1: the beat is dropped and overrun is set to 1. It stays 1 until run=0.
- In ACC, result_data and result_count are driven to 0.
- Reset mid-sequence or mid-EMIT: everything clears at that edge, and the partial bundle is lost.
- An empty sequence is impossible, since a lone last beat is also accumulated (count ≥ 1).

Optional Feature:
- Macro: HV_BUNDLER_TIEBREAK_EN.
- Defined: a DIM+1 tie-break register captures the first accepted beat of each sequence (beat count was 0). A tied bit outputs that register's bit. The register clears with the counters.
- Undefined: a tied bit outputs 0, and no tie-break register exists.

Decomposition:
- Package hdc_pkg:
  - default DIM and CNT_W;
  - typedef hv_t (logic [DIM:0]);
  - enum bundler_state_t {ACC, EMIT};
  - localparam CNT_MAX = 2**(CNT_W-1)-1.
- Sub-module bundle_bit_counter: one signed saturating counter with inc/dec/clear inputs and outputs pos and zero. It is instantiated DIM+1 times via generate. The FSM, beat count, overrun flag and tie-break register stay in hv_bundler.

Test Plan (DIM=7, CNT_W=4 unless stated):
- Reset: hold run=0 for 2 cycles, with store pulses during reset → result_valid=0, result_count=0, overrun=0; no accumulation afterwards.
- Majority of 3: beats 8'hF0, 8'hCC, 8'hAA (last on the third), result_ready=1 → result_valid exactly 1 cycle after the third beat, result_data=8'hE8, result_count=3; the next sequence starts from zero.
- Tie with 2 beats: 8'hF0 then 8'h3C (last), result_ready=1 → result_data=8'h30 without the macro; with the macro, result_data=8'hF0; result_count=2.
- Saturation: 20 beats of 8'hFF then one 8'h00 with last → counters cap at +7, end at 6 → result_data=8'hFF, result_count=21.
- Backpressure and overrun: complete 8'h0F (last), hold result_ready=0 for 5 cycles while sending beat 8'hFF → result_data stays 8'h0F, overrun=1; after ready, the bundle restarts clean and overrun stays 1 until run=0.
- Reset mid-sequence: 2 beats of 8'hFF, run=0 for 1 cycle, then 8'h01 with last → result_data=8'h01, result_count=1.
